// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM state encoding and the iteration counter width.
package muldiv_pkg;

  // Operation select as driven by the control unit.
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Iteration counter width; holds WIDTH (32) down to 0.
  localparam int ITER_W = 6;

  // True for the two divide operations.
  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for the two signed operations.
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate. Used for the operand magnitudes on
// accept and for applying result signs after the unsigned iterations.
module muldiv_sign_fix #(
  parameter int DW = 64
) (
  input  logic [DW-1:0] value,
  input  logic          neg,
  output logic [DW-1:0] result
);

  assign result = neg ? (~value + DW'(1)) : value;

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit beside the single-cycle ALU.
// Signed operations run on magnitudes (shift-add multiply, restoring divide)
// and the signs are reapplied in FIX. A zero divisor skips RUN and goes
// straight to FIX, which publishes the all-ones quotient and the dividend.
// Latency, counting the accepting edge as edge 1: done is visible after
// edge WIDTH+2 (34 for WIDTH=32); 2 edges for a zero divisor.
// Build option MULDIV_EARLY_OUT_EN: multiplies leave RUN as soon as the
// remaining multiplier bits are zero, shifting the partial product into
// place in one step (3 to WIDTH+2 edges). Divides are unaffected.
module alu_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam logic [ITER_W-1:0] ITER_INIT = ITER_W'(WIDTH);

  state_e              state_q, state_d;
  logic                is_mul_q;   // operation in flight is a multiply
  logic                neg_lo_q;   // negate product / quotient in FIX
  logic                neg_hi_q;   // negate remainder in FIX
  logic                dz_q;       // divisor was zero
  logic [WIDTH-1:0]    opnd_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]  p_q;        // {acc/remainder, multiplier/quotient}
  logic [ITER_W-1:0]   cnt_q;

  // Request decode.
  op_e  op_in;
  logic in_div, a_neg, b_neg, b_zero;

  assign op_in  = op_e'(op);
  assign in_div = op_is_div(op_in);
  assign a_neg  = op_is_signed(op_in) & src_a[WIDTH-1];
  assign b_neg  = op_is_signed(op_in) & src_b[WIDTH-1];
  assign b_zero = in_div && (src_b == '0);

  // The two negators are shared between IDLE (operand magnitudes) and FIX
  // (result signs); the states are exclusive so only the inputs are muxed.
  logic               in_fix;
  logic [2*WIDTH-1:0] fix0_in, fix0_out;
  logic [WIDTH-1:0]   fix1_in, fix1_out;
  logic               fix0_neg, fix1_neg;

  assign in_fix   = (state_q == S_FIX);
  assign fix0_in  = in_fix ? (is_mul_q ? p_q : {{WIDTH{1'b0}}, p_q[WIDTH-1:0]})
                           : {{WIDTH{1'b0}}, src_a};
  assign fix0_neg = in_fix ? (neg_lo_q & ~dz_q) : a_neg;
  assign fix1_in  = in_fix ? p_q[2*WIDTH-1:WIDTH] : src_b;
  assign fix1_neg = in_fix ? (neg_hi_q & ~dz_q) : b_neg;

  muldiv_sign_fix #(.DW(2*WIDTH)) u_fix0 (
    .value  (fix0_in),
    .neg    (fix0_neg),
    .result (fix0_out)
  );

  muldiv_sign_fix #(.DW(WIDTH)) u_fix1 (
    .value  (fix1_in),
    .neg    (fix1_neg),
    .result (fix1_out)
  );

  // One iteration of each algorithm.
  logic [WIDTH:0]     mul_sum, rem_ext, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, p_q[WIDTH-1:1]};
  assign rem_ext  = p_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = rem_ext - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {rem_ext[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  // The unconsumed multiplier bits sit in p_q[cnt_q-1:0].
  logic early_out;
`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask  = ~({WIDTH{1'b1}} << cnt_q);
  assign early_out = is_mul_q && ((p_q[WIDTH-1:0] & rem_mask) == '0);
`else
  assign early_out = 1'b0;
`endif

  assign busy = (state_q == S_RUN) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = b_zero ? S_FIX : S_RUN;
      S_RUN:  if (early_out || (cnt_q == ITER_W'(1))) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iterations, sign fix-up and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_mul_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      dz_q        <= 1'b0;
      opnd_q      <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          is_mul_q    <= ~in_div;
          dz_q        <= b_zero;
          cnt_q       <= ITER_INIT;
          div_by_zero <= 1'b0;
          if (b_zero) begin
            p_q      <= {src_a, {WIDTH{1'b1}}};
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
          end else if (in_div) begin
            p_q      <= {{WIDTH{1'b0}}, fix0_out[WIDTH-1:0]};
            opnd_q   <= fix1_out;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;  // remainder follows the dividend
          end else begin
            p_q      <= {{WIDTH{1'b0}}, fix1_out};
            opnd_q   <= fix0_out[WIDTH-1:0];
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= 1'b0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - ITER_W'(1);
          if (early_out)     p_q <= p_q >> cnt_q;
          else if (is_mul_q) p_q <= mul_next;
          else               p_q <= div_next;
        end
        S_FIX: begin
          div_by_zero <= dz_q;
          if (is_mul_q) begin
            {result_hi, result_lo} <= fix0_out;
          end else begin
            result_lo <= fix0_out[WIDTH-1:0];
            result_hi <= fix1_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench for alu_muldiv_unit: the driver pushes model results at
// accept time, a monitor pops and compares on every done pulse.
// Honours MULDIV_EARLY_OUT_EN for multiply latency expectations.
module tb_alu_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int unsigned  acc;
    int           lat_min;
    int           lat_max;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dz);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    dz = 1'b0;
    lo = '0;
    hi = '0;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {hi, lo} = up;
      end
      2'b10: begin
        if (b == 0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = '0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          lo = q; hi = r;
        end
      end
      default: begin
        if (b == 0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  // Issue one request; returns on the falling edge after acceptance.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input int lmax_over);
    exp_t e;
    bit   accepted = 0;
    int   tries = 0;
    model(o, a, b, e.lo, e.hi, e.dz);
    e.tag = tag;
    if (o[1] && b == 0) begin
      e.lat_min = 2; e.lat_max = 2;
    end else if (!o[1]) begin
`ifdef MULDIV_EARLY_OUT_EN
      e.lat_min = 3; e.lat_max = W + 2;
`else
      e.lat_min = W + 2; e.lat_max = W + 2;
`endif
    end else begin
      e.lat_min = W + 2; e.lat_max = W + 2;
    end
    if (lmax_over > 0) e.lat_max = lmax_over;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    while (!accepted && tries < 5) begin
      @(posedge clk);
      #1;
      if (busy) accepted = 1;
      tries++;
    end
    check({tag, "_accept"}, accepted, 1);
    e.acc = cyc;
    if (accepted) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;  // must not matter
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((busy || done) && n < 200);
    check({tag, "_idle_timeout"}, (n < 200), 1);
  endtask

  // Monitor: compare every completion against the oldest expectation.
  bit prev_done = 0;
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        done_seen++;
        check("done_pulse_width", prev_done, 0);
        check("busy_low_at_done", busy, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          lat = int'(cyc - e.acc) + 1;
          check({e.tag, "_lo"}, result_lo, e.lo);
          check({e.tag, "_hi"}, result_hi, e.hi);
          check({e.tag, "_dz"}, div_by_zero, e.dz);
          if (e.lat_min == e.lat_max)
            check({e.tag, "_latency"}, lat, e.lat_min);
          else
            check({e.tag, $sformatf("_latency_%0d_in_range", lat)},
                  (lat >= e.lat_min && lat <= e.lat_max), 1);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    logic [1:0]   o;
    logic [W-1:0] a, b;
    int           sel, d0, n;

    // Reset values.
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_dz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("boot");

    // Directed cases.
    issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max", 0);
    wait_idle("mulu_max");
    issue(OP_MUL, 32'hFFFF_FFF9, 32'd3, "mul_neg", 0);
    wait_idle("mul_neg");
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 0);
    wait_idle("div_neg");
    issue(OP_DIVU, 32'd100, 32'd0, "divu_zero", 0);
    wait_idle("divu_zero");
    issue(OP_DIVU, 32'd100, 32'd7, "divu_after_zero", 0);
    wait_idle("divu_after_zero");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
    wait_idle("div_ovf");
    issue(OP_DIV, 32'h8000_0000, 32'd0, "div_zero_signed", 0);
    wait_idle("div_zero_signed");
`ifdef MULDIV_EARLY_OUT_EN
    issue(OP_MULU, 32'd5, 32'd3, "mulu_small", 5);
`else
    issue(OP_MULU, 32'd5, 32'd3, "mulu_small", 0);
`endif
    wait_idle("mulu_small");

    // start pulsed mid-RUN with other operands must be ignored.
    issue(OP_MUL, 32'd1234, 32'hFFFF_FF00, "mul_poke", 0);
    repeat (9) @(negedge clk);
    op = OP_DIVU; src_a = 32'd99; src_b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mul_poke");

    // Reset in the middle of RUN aborts without a done pulse.
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd3, "abort", 0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_lo", result_lo, 0);
    check("abort_hi", result_hi, 0);
    check("abort_dz", div_by_zero, 0);
    if (sb.size() > 0) void'(sb.pop_back());
    d0 = done_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", done_seen, d0);

    // Randomized traffic with a bias toward the corner operands.
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: b = 32'd1;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        4: b = 32'($urandom_range(0, 255)) | 32'h8000_0000;
        default: ;
      endcase
      issue(o, a, b, $sformatf("rnd%0d_op%0d", i, o), 0);
      wait_idle("rnd");
    end

    // Drain any outstanding expectations.
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
